// File: rtl/debounce_pkg.sv
// Shared types for the input debouncer.
//   debounce_state_t : stability FSM states. The WAIT states count
//                      consecutive samples of the new level before it is
//                      committed.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } debounce_state_t;

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// sync_chain: N-flop synchronizer for one asynchronous input bit.
// Only the first flop samples d. Each flop resets to RST_VAL.
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   d    in  asynchronous input
//   q    out synchronized output (last stage)
module sync_chain #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= {STAGES{RST_VAL}};
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: turns a raw board input into a clean synchronous level
// with one-cycle rise/fall strobes. A new level is committed only after
// DEBOUNCE_CYCLES consecutive synchronized samples of that level.
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   sig_in    in  raw asynchronous input
//   sig_out   out debounced level (after optional inversion)
//   rise      out one-cycle strobe when sig_out commits 0->1
//   fall      out one-cycle strobe when sig_out commits 1->0
//   bouncing  out high while a new level is being qualified
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter bit          INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic sig_out,
  output logic rise,
  output logic fall,
  output logic bouncing
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sync_raw;
  logic sig_sync;

  debounce_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_d, rise_d, fall_d, bouncing_d;

  // Flops reset to INVERT so the inverted view reads 0 during reset.
  sync_chain #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (INVERT)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sig_in),
    .q   (sync_raw)
  );

  assign sig_sync = sync_raw ^ INVERT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOW;
      cnt_q    <= '0;
      sig_out  <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      bouncing <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sig_out  <= out_d;
      rise     <= rise_d;
      fall     <= fall_d;
      bouncing <= bouncing_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = sig_out;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      S_LOW: begin
        if (sig_sync) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      S_WAIT_HIGH: begin
        if (!sig_sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          out_d   = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sig_sync) begin
          state_d = S_WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      S_WAIT_LOW: begin
        if (sig_sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          out_d   = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase

    // Registered from the next state so it lines up with state_q.
    bouncing_d = (state_d == S_WAIT_HIGH) || (state_d == S_WAIT_LOW);
  end

endmodule
